// File: rtl/shift_sub_div.sv
// shift_sub_div: sequential unsigned restoring divider, one quotient bit per clock
// with a start/done pulse-and-level handshake.
module shift_sub_div #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH:0]   r_q, r_d, r_sh, t;
  logic [WIDTH-1:0] q_q, q_d, q_sh, d_q, d_d, quo_q, quo_d, rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d;
  always_comb begin
    r_sh    = (r_q << 1) | (WIDTH+1)'(q_q[WIDTH-1]);
    t       = r_sh - {1'b0, d_q};
    q_sh    = {q_q[WIDTH-2:0], ~t[WIDTH]};
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    if (state_q == RUN) begin
      r_d   = t[WIDTH] ? r_sh : t;
      q_d   = q_sh;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH-1)) begin
        state_d = DONE;
        quo_d   = q_sh;
        rem_d   = r_d[WIDTH-1:0];
      end
    end else if (start) begin
      if (divisor != '0) begin
        state_d = RUN;
        r_d     = '0;
        q_d     = dividend;
        d_d     = divisor;
        cnt_d   = '0;
        dbz_d   = 1'b0;
      end else begin
        state_d = DONE;
        quo_d   = '1;
        rem_d   = dividend;
        dbz_d   = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end
  assign busy        = state_q == RUN;
  assign done        = state_q == DONE;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_shift_sub_div.sv
// tb_shift_sub_div: randomized and directed checks of shift_sub_div at WIDTH=8 and WIDTH=16
// against plain integer division.
module tb_shift_sub_div;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, sel16 = 1'b0;
  logic [15:0] dividend = '0, divisor = '0;
  logic        busy8, done8, dbz8, busy16, done16, dbz16;
  logic [7:0]  q8, r8;
  logic [15:0] q16, r16;
  logic        busy_m, done_m, dbz_m;
  logic [15:0] q_m, r_m;
  int          n_checks = 0, n_fail = 0, lat, bcnt;

  always #5 clk = ~clk;

  shift_sub_div #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel16),
    .dividend(dividend[7:0]), .divisor(divisor[7:0]),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(dbz8));

  shift_sub_div #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start & sel16),
    .dividend(dividend), .divisor(divisor),
    .busy(busy16), .done(done16), .quotient(q16), .remainder(r16), .div_by_zero(dbz16));

  assign busy_m = sel16 ? busy16 : busy8;
  assign done_m = sel16 ? done16 : done8;
  assign dbz_m  = sel16 ? dbz16 : dbz8;
  assign q_m    = sel16 ? q16 : {8'b0, q8};
  assign r_m    = sel16 ? r16 : {8'b0, r8};

  task automatic wait_done();
    lat = 0;
    bcnt = 0;
    while (!done_m && lat < 40) begin
      if (busy_m) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic pulse_op(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done();
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({busy8, done8, dbz8, q8, r8} !== '0) begin
      n_fail++;
      $display("FAIL reset8: busy=%b done=%b dbz=%b q=%0d r=%0d, want all 0", busy8, done8, dbz8, q8, r8);
    end
    n_checks++;
    if ({busy16, done16, dbz16, q16, r16} !== '0) begin
      n_fail++;
      $display("FAIL reset16: busy=%b done=%b dbz=%b q=%0d r=%0d, want all 0", busy16, done16, dbz16, q16, r16);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    pulse_op(200, 7);
    n_checks++;
    if (lat !== 8 || bcnt !== 8 || busy_m !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_timing: lat=%0d busy_cycles=%0d busy=%b, want 8 8 0", lat, bcnt, busy_m);
    end
    n_checks++;
    if (q_m !== 16'd28 || r_m !== 16'd4 || dbz_m !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: q=%0d r=%0d dbz=%b, want 28 4 0", q_m, r_m, dbz_m);
    end
  endtask

  task automatic test_boundaries();
    logic [15:0] ta [4] = '{16'd255, 16'd5, 16'd255, 16'd0};
    logic [15:0] tb [4] = '{16'd1, 16'd9, 16'd255, 16'd13};
    logic [15:0] tq [4] = '{16'd255, 16'd0, 16'd1, 16'd0};
    logic [15:0] tr [4] = '{16'd0, 16'd5, 16'd0, 16'd0};
    for (int i = 0; i < 4; i++) begin
      pulse_op(ta[i], tb[i]);
      n_checks++;
      if (lat !== 8 || q_m !== tq[i] || r_m !== tr[i] || dbz_m !== 1'b0) begin
        n_fail++;
        $display("FAIL boundary %0d/%0d: lat=%0d q=%0d r=%0d dbz=%b, want 8 %0d %0d 0",
                 ta[i], tb[i], lat, q_m, r_m, dbz_m, tq[i], tr[i]);
      end
    end
  endtask

  task automatic test_div_by_zero();
    pulse_op(100, 0);
    n_checks++;
    if (lat !== 0 || bcnt !== 0 || dbz_m !== 1'b1 || q_m !== 16'd255 || r_m !== 16'd100) begin
      n_fail++;
      $display("FAIL div_by_zero: lat=%0d busy_cycles=%0d dbz=%b q=%0d r=%0d, want 0 0 1 255 100",
               lat, bcnt, dbz_m, q_m, r_m);
    end
    pulse_op(100, 10);
    n_checks++;
    if (lat !== 8 || dbz_m !== 1'b0 || q_m !== 16'd10 || r_m !== 16'd0) begin
      n_fail++;
      $display("FAIL after_zero: lat=%0d dbz=%b q=%0d r=%0d, want 8 0 10 0", lat, dbz_m, q_m, r_m);
    end
  endtask

  task automatic test_start_in_run();
    @(negedge clk);
    dividend = 200;
    divisor = 7;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    bcnt = 0;
    while (!done_m && lat < 40) begin
      if (busy_m) bcnt++;
      start = (lat == 3);
      if (lat == 3) begin
        dividend = 9;
        divisor = 3;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    n_checks++;
    if (lat !== 8 || bcnt !== 8 || q_m !== 16'd28 || r_m !== 16'd4) begin
      n_fail++;
      $display("FAIL start_in_run: lat=%0d busy_cycles=%0d q=%0d r=%0d, want 8 8 28 4", lat, bcnt, q_m, r_m);
    end
    @(negedge clk);
    n_checks++;
    if (done_m !== 1'b1 || busy_m !== 1'b0 || q_m !== 16'd28) begin
      n_fail++;
      $display("FAIL start_in_run_hold: done=%b busy=%b q=%0d, want 1 0 28", done_m, busy_m, q_m);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    dividend = 200;
    divisor = 7;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy8, done8, dbz8, q8, r8} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_run: busy=%b done=%b dbz=%b q=%0d r=%0d, want all 0", busy8, done8, dbz8, q8, r8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulse_op(50, 6);
    n_checks++;
    if (lat !== 8 || q_m !== 16'd8 || r_m !== 16'd2 || dbz_m !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset: lat=%0d q=%0d r=%0d dbz=%b, want 8 8 2 0", lat, q_m, r_m, dbz_m);
    end
  endtask

  task automatic test_back_to_back(input logic w16, input int n);
    logic [15:0] mask, a, b, eq, er;
    logic [31:0] recon;
    int wd;
    @(negedge clk);
    sel16 = w16;
    mask = w16 ? 16'hffff : 16'h00ff;
    wd = w16 ? 16 : 8;
    a = 16'($urandom) & mask;
    b = ($urandom_range(0, 15) == 0) ? 16'd0 :
        ($urandom_range(0, 1) != 0) ? (16'($urandom) & mask) : 16'($urandom_range(1, 15));
    dividend = a;
    divisor = b;
    start = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (done_m !== (b == 0)) begin
        n_fail++;
        $display("FAIL b2b_done_pulse w=%0d op %0d: done=%b, want %b", wd, i, done_m, b == 0);
      end
      wait_done();
      eq = (b == 0) ? mask : a / b;
      er = (b == 0) ? a : a % b;
      n_checks++;
      if (lat !== ((b == 0) ? 0 : wd) || q_m !== eq || r_m !== er || dbz_m !== (b == 0)) begin
        n_fail++;
        $display("FAIL b2b_result w=%0d %0d/%0d: lat=%0d q=%0d r=%0d dbz=%b, want %0d %0d %0d %b",
                 wd, a, b, lat, q_m, r_m, dbz_m, (b == 0) ? 0 : wd, eq, er, b == 0);
      end
      if (b != 0) begin
        recon = q_m * b + r_m;
        n_checks++;
        if (recon !== {16'b0, a} || r_m >= b) begin
          n_fail++;
          $display("FAIL b2b_invariant w=%0d %0d/%0d: q*d+r=%0d r=%0d, want %0d and r<%0d",
                   wd, a, b, recon, r_m, a, b);
        end
      end
      a = 16'($urandom) & mask;
      b = ($urandom_range(0, 15) == 0) ? 16'd0 :
          ($urandom_range(0, 1) != 0) ? (16'($urandom) & mask) : 16'($urandom_range(1, 15));
      dividend = a;
      divisor = b;
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_div_by_zero();
    test_start_in_run();
    test_reset_mid_run();
    test_back_to_back(1'b0, 2000);
    test_back_to_back(1'b1, 2000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
